mul_div_iter: RTL

Parametrised iterative integer multiply/divide unit, the successor of the fixed 32-bit Booth/restoring mul/div block. It accepts one operation through a ready/start handshake, iterates one bit per clock, and returns the full double-width product or quotient plus remainder. Signed or unsigned operation is selected per operation. It sits beside the main ALU in the execute stage and stalls the pipeline via `data_inputRDY` and `data_resultRDY`.

---
 rtl/mul_div_pkg.sv | 21 ++
 rtl/mul_div_addsub.sv | 18 +
 rtl/mul_div_iter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    // Bits needed for an iteration counter that runs from width-1 down to 0.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_div_addsub.sv
// N-bit adder/subtractor with carry-out; subtract computes a + ~b + 1.
module mul_div_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, (i_sub ? ~i_b : i_b)} + {{N{1'b0}}, i_sub};
    assign o_sum  = w_full[N-1:0];
    assign o_cout = w_full[N];

endmodule

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock,
// operating on magnitudes with a final sign-correction cycle.
module mul_div_iter
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic             data_inputRDY,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_resultHI,
    output logic             data_resultOP,
    output logic             data_exception
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state, w_next;
    op_t              r_op, r_res_op;
    logic             r_sign_a, r_sign_b, r_exc;
    logic [WIDTH-1:0] r_b, r_hi, r_lo, r_res, r_res_hi;
    logic [CW-1:0]    r_cnt;

    logic             w_start, w_div0, w_sign_a, w_sign_b, w_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_fix_lo, w_fix_hi;
    logic [WIDTH:0]   w_lo_a, w_lo_b, w_lo_sum, w_hi_b, w_hi_sum;
    logic             w_lo_sub, w_lo_cout, w_hi_cout, w_unused;

    assign data_inputRDY  = (r_state == IDLE) || (r_state == DONE);
    assign data_resultRDY = (r_state == DONE);
    assign data_result    = r_res;
    assign data_resultHI  = r_res_hi;
    assign data_resultOP  = r_res_op;
    assign data_exception = r_exc;

    assign w_start = data_inputRDY && (ctrl_MULT ^ ctrl_DIV);
    assign w_div0  = ctrl_DIV && (data_operandB == '0);

    // While idle the shared adders negate the raw operands for magnitude capture.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_lo_a   = '0;
        w_lo_b   = {1'b0, data_operandA};
        w_lo_sub = 1'b1;
        if (r_state == RUN) begin
            w_lo_b = {1'b0, r_b};
            if (r_op == OP_DIV) begin
                w_lo_a = {r_hi, r_lo[WIDTH-1]};
            end else begin
                w_lo_a   = {1'b0, r_hi};
                w_lo_sub = 1'b0;
            end
        end else if (r_state == FIX) begin
            w_lo_b = {1'b0, r_lo};
        end
    end

    assign w_hi_b = data_inputRDY ? {1'b0, data_operandB} : {1'b0, r_hi};

    mul_div_addsub #(.N(WIDTH + 1)) u_addsub_lo (
        .i_a    (w_lo_a),
        .i_b    (w_lo_b),
        .i_sub  (w_lo_sub),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    mul_div_addsub #(.N(WIDTH + 1)) u_addsub_hi (
        .i_a    ('0),
        .i_b    (w_hi_b),
        .i_sub  (1'b1),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    assign w_unused = w_hi_cout ^ w_hi_sum[WIDTH];

    assign w_sign_a = ctrl_SIGNED & data_operandA[WIDTH-1];
    assign w_sign_b = ctrl_SIGNED & data_operandB[WIDTH-1];
    assign w_mag_a  = w_sign_a ? w_lo_sum[WIDTH-1:0] : data_operandA;
    assign w_mag_b  = w_sign_b ? w_hi_sum[WIDTH-1:0] : data_operandB;

    // A 2W negation borrows into the high half only when the low half is zero.
    always_comb begin
        w_neg    = r_sign_a ^ r_sign_b;
        w_fix_lo = w_neg ? w_lo_sum[WIDTH-1:0] : r_lo;
        w_fix_hi = r_hi;
        if (r_op == OP_DIV) begin
            if (r_sign_a) w_fix_hi = w_hi_sum[WIDTH-1:0];
        end else if (w_neg) begin
            w_fix_hi = w_lo_cout ? w_hi_sum[WIDTH-1:0] : ~r_hi;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start)               w_next = w_div0 ? DONE : RUN;
                else if (r_state == DONE)  w_next = IDLE;
            end
            RUN:     if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_res_hi <= '0;
            r_res_op <= OP_MUL;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_op     <= ctrl_DIV ? OP_DIV : OP_MUL;
                        r_cnt    <= CNT_LAST;
                        r_hi     <= '0;
                        r_lo     <= ctrl_DIV ? w_mag_a : w_mag_b;
                        r_b      <= ctrl_DIV ? w_mag_b : w_mag_a;
                        if (w_div0) begin
                            r_res    <= '1;
                            r_res_hi <= data_operandA;
                            r_res_op <= OP_DIV;
                            r_exc    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_op == OP_DIV) begin
                        r_hi <= w_lo_cout ? w_lo_sum[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                        r_lo <= {r_lo[WIDTH-2:0], w_lo_cout};
                    end else if (r_lo[0]) begin
                        {r_hi, r_lo} <= {w_lo_sum, r_lo[WIDTH-1:1]};
                    end else begin
                        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    r_res    <= w_fix_lo;
                    r_res_hi <= w_fix_hi;
                    r_res_op <= r_op;
                    r_exc    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
